accelerator_tcdm_responder: RTL



---
 rtl/accelerator_tcdm_responder_pkg.sv | 33 +++
 rtl/accelerator_tcdm_responder_if.sv | 25 ++
 rtl/accelerator_tcdm_responder_bank.sv | 87 ++++++++
 rtl/accelerator_tcdm_responder.sv | 123 ++++++++++++
 4 files changed

// File: rtl/accelerator_tcdm_responder_pkg.sv
// Shared types and helpers for the word-interleaved TCDM responder and its banks.
package accelerator_package;

  typedef struct packed {
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
  } tcdm_req_t;

  localparam logic [15:0] TCDM_LFSR_SEED   = 16'hACE1;
  localparam int unsigned TCDM_BYTE_OFFSET = 32'd2;

  // Index width for n entries; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    if (n > 32'd1) begin
      return $clog2(n);
    end else begin
      return 32'd1;
    end
  endfunction

  function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int k = 0; k < 4; k++) begin
      res[8*k +: 8] = be[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/accelerator_tcdm_responder_if.sv
// TCDM bundle between the streamer's master ports and the responder.
interface accelerator_tcdm_responder_if #(
  parameter int unsigned MP = 4
) ();

  logic [MP-1:0]       tcdm_req;
  logic [MP-1:0]       tcdm_gnt;
  logic [MP-1:0][31:0] tcdm_add;
  logic [MP-1:0]       tcdm_wen;
  logic [MP-1:0][3:0]  tcdm_be;
  logic [MP-1:0][31:0] tcdm_data;
  logic [MP-1:0][31:0] tcdm_r_data;
  logic [MP-1:0]       tcdm_r_valid;

  modport master (
    output tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_data,
    input  tcdm_gnt, tcdm_r_data, tcdm_r_valid
  );

  modport slave (
    input  tcdm_req, tcdm_add, tcdm_wen, tcdm_be, tcdm_data,
    output tcdm_gnt, tcdm_r_data, tcdm_r_valid
  );

endinterface

// File: rtl/accelerator_tcdm_responder_bank.sv
// One interleaved bank: round-robin arbiter over all ports, storage array and
// the combinational read word of the current winner.
module accelerator_tcdm_bank
  import accelerator_package::*;
#(
  parameter int unsigned MP         = 4,
  parameter int unsigned BANK_WORDS = 64,
  localparam int unsigned RW        = idx_width(BANK_WORDS)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic [MP-1:0]          req_i,
  input  logic [MP-1:0][RW-1:0]  row_i,
  input  tcdm_req_t [MP-1:0]     port_i,
  output logic [MP-1:0]          gnt_o,
  output logic [31:0]            rdata_o
);

  localparam int unsigned PW = idx_width(MP);

  logic [PW-1:0]   ptr_q, ptr_d, winner;
  logic            found;
  logic [2*MP-1:0] req_rot;
  logic [31:0]     mem_q [BANK_WORDS];
  logic            wr_en;
  logic [RW-1:0]   wr_row;
  logic [31:0]     wr_word;
  logic            unused_add;

  // Rotating the doubled request vector puts the pointer at bit 0, so the
  // first set bit is the round-robin winner.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    req_rot = {req_i, req_i} >> ptr_q;
    for (int k = 0; k < MP; k++) begin
      if (!found && req_rot[k]) begin
        found  = 1'b1;
        winner = ((int'(ptr_q) + k) >= int'(MP)) ? PW'(int'(ptr_q) + k - int'(MP))
                                                 : PW'(int'(ptr_q) + k);
      end else begin
        found = found;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < MP; k++) begin
      gnt_o[k] = found && (winner == PW'(k));
    end
    rdata_o = mem_q[row_i[winner]];
    wr_en   = found && !port_i[winner].wen;
    wr_row  = row_i[winner];
    wr_word = be_merge(mem_q[wr_row], port_i[winner].data, port_i[winner].be);
    if (clear_i) begin
      ptr_d = '0;
    end else if (found) begin
      ptr_d = (winner == PW'(MP - 32'd1)) ? '0 : winner + PW'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_comb begin
    unused_add = 1'b0;
    for (int k = 0; k < MP; k++) begin
      unused_add = unused_add ^ (^port_i[k].add);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Storage is not reset; a write whose edge lands while reset is held is dropped.
  always_ff @(posedge clk_i) begin
    if (wr_en && !rst_i) begin
      mem_q[wr_row] <= wr_word;
    end
  end

endmodule

// File: rtl/accelerator_tcdm_responder.sv
// Multi-port word-interleaved TCDM responder. Optional random grant stalls are
// enabled with the TCDM_RESPONDER_STALL_EN macro.
module accelerator_tcdm_responder
  import accelerator_package::*;
#(
  parameter int unsigned MP         = 4,
  parameter int unsigned NB_BANKS   = 8,
  parameter int unsigned BANK_WORDS = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  accelerator_tcdm_responder_if.slave  tcdm
);

  localparam int unsigned BW = idx_width(NB_BANKS);
  localparam int unsigned RW = idx_width(BANK_WORDS);

  logic [MP-1:0]                 req_eff, gnt, stall_mask;
  logic [MP-1:0][BW-1:0]         bank_idx;
  logic [MP-1:0][RW-1:0]         row_idx;
  tcdm_req_t [MP-1:0]            port_req;
  logic [NB_BANKS-1:0][MP-1:0]   bank_req, bank_gnt;
  logic [NB_BANKS-1:0][31:0]     bank_rdata;
  logic [MP-1:0]                 r_valid_q, r_valid_d;
  logic [MP-1:0][31:0]           r_data_q, r_data_d;

  always_comb begin
    for (int p = 0; p < MP; p++) begin
      bank_idx[p]      = tcdm.tcdm_add[p][TCDM_BYTE_OFFSET +: BW];
      row_idx[p]       = tcdm.tcdm_add[p][TCDM_BYTE_OFFSET + BW +: RW];
      port_req[p].add  = tcdm.tcdm_add[p];
      port_req[p].wen  = tcdm.tcdm_wen[p];
      port_req[p].be   = tcdm.tcdm_be[p];
      port_req[p].data = tcdm.tcdm_data[p];
    end
  end

`ifdef TCDM_RESPONDER_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    if (clear_i) begin
      lfsr_d = TCDM_LFSR_SEED;
    end else begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    for (int p = 0; p < MP; p++) begin
      stall_mask[p] = lfsr_q[p % 16] & lfsr_q[(p + 5) % 16];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= TCDM_LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign stall_mask = '0;
`endif

  // A stalled port is invisible to arbitration, so bank pointers never move for it.
  always_comb begin
    req_eff = tcdm.tcdm_req & ~stall_mask;
    for (int b = 0; b < NB_BANKS; b++) begin
      for (int p = 0; p < MP; p++) begin
        bank_req[b][p] = req_eff[p] && (bank_idx[p] == BW'(b));
      end
    end
  end

  for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
    accelerator_tcdm_bank #(
      .MP         (MP),
      .BANK_WORDS (BANK_WORDS)
    ) i_bank (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (clear_i),
      .req_i   (bank_req[b]),
      .row_i   (row_idx),
      .port_i  (port_req),
      .gnt_o   (bank_gnt[b]),
      .rdata_o (bank_rdata[b])
    );
  end

  always_comb begin
    gnt = '0;
    for (int b = 0; b < NB_BANKS; b++) begin
      gnt = gnt | bank_gnt[b];
    end
  end

  assign tcdm.tcdm_gnt = gnt;

  always_comb begin
    r_valid_d = clear_i ? '0 : gnt;
    for (int p = 0; p < MP; p++) begin
      if (gnt[p] && !clear_i) begin
        r_data_d[p] = tcdm.tcdm_wen[p] ? bank_rdata[bank_idx[p]] : 32'h0000_0000;
      end else begin
        r_data_d[p] = r_data_q[p];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid_q <= '0;
      r_data_q  <= '0;
    end else begin
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
    end
  end

  assign tcdm.tcdm_r_valid = r_valid_q;
  assign tcdm.tcdm_r_data  = r_data_q;

endmodule
